baud_gen: RTL

Two-channel UART baud-rate generator, the parametrised successor of the 8-bit `divisor`/`counter` pair. It produces independent RX and TX oversampling ticks from one clock, with a configurable divisor width and an optional fractional divisor. An RX phase-resync input lets the receiver align sampling to a detected start edge. Per-channel bit strobes fire once every `OSR` ticks. The block sits between the UART register file, which supplies the divisors, and the RX/TX shift engines, which consume the ticks and strobes.

---
 rtl/baud_gen.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/baud_gen.sv
// Two-channel UART baud-rate generator: RX/TX oversample ticks plus bit strobes every OSR ticks.
// Define BAUD_GEN_FRAC_EN to add the fractional-divisor accumulators.

module baud_chan #(
  parameter int CNT_W  = 16,
  parameter int FRAC_W = 4,
  parameter int OSR    = 16
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              en_i,
  input  logic              sync_i,
  input  logic [CNT_W-1:0]  div_i,
  input  logic [FRAC_W-1:0] frac_i,
  output logic              tick_o,
  output logic              bit_o
);
  localparam int OSR_W = $clog2(OSR);

  logic [CNT_W-1:0] cnt_q, cnt_d, deff, reload;
  logic [OSR_W-1:0] osr_q, osr_d;
  logic             tick_q, tick_d, bit_q, bit_d;
  logic             carry;
  logic             reload_en;

  assign deff      = (div_i == '0) ? CNT_W'(1) : div_i;
  // deff >= 1, so deff-1+carry stays within CNT_W bits
  assign reload    = deff - CNT_W'(1) + CNT_W'(carry);
  assign reload_en = en_i && !sync_i && (cnt_q == '0);

`ifdef BAUD_GEN_FRAC_EN
  logic [FRAC_W-1:0] acc_q, acc_d, acc_sum;

  assign {carry, acc_sum} = {1'b0, acc_q} + {1'b0, frac_i};

  always_comb begin
    acc_d = acc_q;
    if (sync_i)         acc_d = '0;
    else if (reload_en) acc_d = acc_sum;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) acc_q <= '0;
    else         acc_q <= acc_d;
  end
`else
  logic unused_frac;
  assign unused_frac = ^frac_i;
  assign carry       = 1'b0;
`endif

  always_comb begin
    cnt_d  = cnt_q;
    osr_d  = osr_q;
    tick_d = 1'b0;
    bit_d  = 1'b0;
    if (sync_i) begin
      // restart mid-period so RX samples near bit centres
      cnt_d = deff >> 1;
      osr_d = '0;
    end else if (en_i) begin
      if (cnt_q == '0) begin
        tick_d = 1'b1;
        cnt_d  = reload;
        if (osr_q == OSR_W'(OSR - 1)) begin
          bit_d = 1'b1;
          osr_d = '0;
        end else begin
          osr_d = osr_q + 1'b1;
        end
      end else begin
        cnt_d = cnt_q - 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q  <= '0;
      osr_q  <= '0;
      tick_q <= 1'b0;
      bit_q  <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      osr_q  <= osr_d;
      tick_q <= tick_d;
      bit_q  <= bit_d;
    end
  end

  assign tick_o = tick_q;
  assign bit_o  = bit_q;

  a_bit_in_tick: assert property (@(posedge clk_i) disable iff (!rst_ni) bit_q |-> tick_q);

endmodule

module baud_gen #(
  parameter int CNT_W  = 16,
  parameter int FRAC_W = 4,
  parameter int OSR    = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic [CNT_W-1:0]  div_rx,
  input  logic [FRAC_W-1:0] frac_rx,
  input  logic [CNT_W-1:0]  div_tx,
  input  logic [FRAC_W-1:0] frac_tx,
  input  logic              rx_sync,
  output logic              tick_rx,
  output logic              bit_rx,
  output logic              tick_tx,
  output logic              bit_tx
);
  localparam int NUM_CH = 2;  // lane 0 = RX, lane 1 = TX

  logic [NUM_CH-1:0][CNT_W-1:0]  div_all;
  logic [NUM_CH-1:0][FRAC_W-1:0] frac_all;
  logic [NUM_CH-1:0]             sync_all, tick_all, bit_all;

  assign div_all  = {div_tx, div_rx};
  assign frac_all = {frac_tx, frac_rx};
  assign sync_all = {1'b0, rx_sync};

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    baud_chan #(.CNT_W(CNT_W), .FRAC_W(FRAC_W), .OSR(OSR)) u_ch (
      .clk_i  (clk),
      .rst_ni (rst_n),
      .en_i   (en),
      .sync_i (sync_all[g]),
      .div_i  (div_all[g]),
      .frac_i (frac_all[g]),
      .tick_o (tick_all[g]),
      .bit_o  (bit_all[g])
    );
  end

  assign tick_rx = tick_all[0];
  assign bit_rx  = bit_all[0];
  assign tick_tx = tick_all[1];
  assign bit_tx  = bit_all[1];

endmodule
